l2_cache_control: RTL

//  FSM controller for the 2-way L2 cache built from two l2_cache_set arrays.

---
 rtl/l2_cache_control_if.sv | 35 +++
 rtl/l2_cache_control.sv | 110 +++++++++++
 2 files changed

// File: rtl/l2_cache_control_if.sv
// Bundle of the upstream request, datapath status/control and pmem handshake
// signals between the L2 cache controller and its environment.
interface l2_cache_control_if #(
  parameter int INDEX_W = 3
);
  logic               mem_read;
  logic               mem_write;
  logic               mem_resp;
  logic [INDEX_W-1:0] in_index;
  logic [1:0]         hit;
  logic [1:0]         valid;
  logic [1:0]         dirty;
  logic [1:0]         set_load;
  logic               write_type;
  logic               data_sel;
  logic               pmem_addr_sel;
  logic               victim_way;
  logic               pmem_read;
  logic               pmem_write;
  logic               pmem_resp;

  // Environment side: upstream requester, datapath status and pmem responder.
  modport master (
    output mem_read, mem_write, in_index, hit, valid, dirty, pmem_resp,
    input  mem_resp, set_load, write_type, data_sel, pmem_addr_sel,
           victim_way, pmem_read, pmem_write
  );

  // Controller side.
  modport slave (
    input  mem_read, mem_write, in_index, hit, valid, dirty, pmem_resp,
    output mem_resp, set_load, write_type, data_sel, pmem_addr_sel,
           victim_way, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_cache_control.sv
// Control FSM for a 2-way L2 cache: zero-cycle hits, dirty-victim writeback,
// line allocation over the pmem handshake, and per-index LRU tracking.
module l2_cache_control #(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l2_cache_control_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e               state, state_next;
  logic [NUM_LINES-1:0] lru;          // lru[i] = way to evict next at index i
  logic                 victim_way_q;

  logic req, is_write, any_hit, hit_way, lru_cur;
  logic lru_upd, lru_way, latch_victim;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign any_hit  = |bus.hit;
  assign hit_way  = ~bus.hit[0];        // way0 wins when both ways match
  assign lru_cur  = lru[bus.in_index];

  assign bus.victim_way = victim_way_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the LRU array is small flop storage and must come up as all-zero,
  // so it is reset like any other register rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lru          <= '0;
      victim_way_q <= 1'b0;
    end else begin
      state <= state_next;
      if (lru_upd)      lru[bus.in_index] <= ~lru_way;
      if (latch_victim) victim_way_q      <= lru_cur;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next        = state;
    lru_upd           = 1'b0;
    lru_way           = 1'b0;
    latch_victim      = 1'b0;
    bus.mem_resp      = 1'b0;
    bus.set_load      = 2'b00;
    bus.write_type    = 1'b0;
    bus.data_sel      = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;

    // Outputs are held quiet while reset is asserted, even mid-transaction.
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (req && any_hit) begin
            bus.mem_resp = 1'b1;
            lru_upd      = 1'b1;
            lru_way      = hit_way;
            if (is_write) begin
              bus.set_load[hit_way] = 1'b1;
              bus.write_type        = 1'b1;
              bus.data_sel          = 1'b0;
            end
          end else if (req) begin
            latch_victim = 1'b1;
            if (bus.valid[lru_cur] && bus.dirty[lru_cur])
              state_next = WRITEBACK;
            else
              state_next = ALLOCATE;
          end
        end

        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          if (bus.pmem_resp) state_next = ALLOCATE;
        end

        ALLOCATE: begin
          bus.pmem_read     = 1'b1;
          bus.pmem_addr_sel = 1'b0;
          if (bus.pmem_resp) begin
            bus.set_load[victim_way_q] = 1'b1;
            bus.write_type             = 1'b0;
            bus.data_sel               = 1'b1;
            lru_upd                    = 1'b1;
            lru_way                    = victim_way_q;
            state_next                 = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule
